// File: rtl/register_pipe_defs_bdeduffy.sv
// ============================================================================
// Module   : register_pipe_defs_bdeduffy (package)
// Brief    : Shared defaults and count-width helper for the elastic register pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package register_pipe_defs_bdeduffy;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_DEPTH = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_pipe_stage_bdeduffy.sv
// ============================================================================
// Module   : register_pipe_stage_bdeduffy
// Brief    : One pipe stage: loadable data register plus set/clear valid flop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module register_pipe_stage_bdeduffy
    import register_pipe_defs_bdeduffy::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             set_valid,
    input  logic             clr_valid,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] data_d;
    logic             valid_d;

    // Set wins over clear: a stage refilled while its old word moves on stays valid.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d = d;
        end
        if (set_valid) begin
            valid_d = 1'b1;
        end else if (clr_valid) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/register_pipe_bdeduffy.sv
// ============================================================================
// Module   : register_pipe_bdeduffy
// Brief    : Elastic DEPTH-stage register pipe with bubble collapsing, flush
//            and registered occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module register_pipe_bdeduffy
    import register_pipe_defs_bdeduffy::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_data,
    input  logic                            out_ready,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int C_CNT_W = count_width(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_leave;
    logic [DEPTH-1:0] w_free;
    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [WIDTH-1:0] w_din  [DEPTH];
    logic             w_accept;
    logic             w_drain;

    logic [C_CNT_W-1:0] count_d;
    logic [C_CNT_W-1:0] count_q;

    // Ready ripples backwards from the output: a stage is free if empty or leaving.
    always_comb begin
        w_leave = '0;
        w_free  = '0;
        w_leave[DEPTH-1] = w_valid[DEPTH-1] && out_ready;
        w_free[DEPTH-1]  = !w_valid[DEPTH-1] || w_leave[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_leave[k] = w_valid[k] && w_free[k+1];
            w_free[k]  = !w_valid[k] || w_leave[k];
        end
    end

    assign in_ready = w_free[0] && !flush && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = w_leave[DEPTH-1];

    always_comb begin
        w_din[0]  = in_data;
        w_load    = '0;
        w_load[0] = w_accept;
        for (int k = 1; k < DEPTH; k++) begin
            w_din[k]  = w_data[k-1];
            w_load[k] = w_leave[k-1] && !flush;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            register_pipe_stage_bdeduffy #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .load      (w_load[g]),
                .d         (w_din[g]),
                .set_valid (w_load[g]),
                .clr_valid (w_leave[g] || flush),
                .data_q    (w_data[g]),
                .valid_q   (w_valid[g])
            );
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (w_accept && !w_drain) begin
            count_d = count_q + C_CNT_W'(1);
        end else if (!w_accept && w_drain) begin
            count_d = count_q - C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_register_pipe_bdeduffy.sv
// ============================================================================
// Module   : tb_register_pipe_bdeduffy
// Brief    : Randomized + directed bench for the default build and a 1x1 build.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_register_pipe_bdeduffy;
    import register_pipe_defs_bdeduffy::*;

    localparam int W0 = DEF_WIDTH;
    localparam int D0 = DEF_DEPTH;
    localparam int W1 = 1;
    localparam int D1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;
    logic iv0, ir0, ov0, or0;
    logic [W0-1:0] id0, od0;
    logic [count_width(D0)-1:0] cnt0;
    logic iv1, ir1, ov1, or1;
    logic [W1-1:0] id1, od1;
    logic [count_width(D1)-1:0] cnt1;

    register_pipe_bdeduffy #(.WIDTH(W0), .DEPTH(D0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv0), .in_data(id0),
        .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_ready(or0), .count(cnt0)
    );

    register_pipe_bdeduffy #(.WIDTH(W1), .DEPTH(D1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_data(id1),
        .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(or1), .count(cnt1)
    );

    // Reference: ordered list of held words, each tagged with its stage position.
    typedef struct {
        logic [63:0] d;
        int          pos;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [63:0] last_d [2];
    int          dep    [2];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Oldest word first: it advances unless the word ahead stays put in its target slot.
    task automatic model_step(input int m, input bit ordy, input bit push,
                              input logic [63:0] din, input bit commit, output bit free0);
        ent_t        w[$];
        ent_t        e;
        logic [63:0] nl;
        int          blk;
        bit          gone;
        if (m == 0) w = q0; else w = q1;
        nl   = last_d[m];
        gone = 1'b0;
        blk  = dep[m];
        for (int i = 0; i < w.size(); i++) begin
            if (w[i].pos == dep[m] - 1) begin
                if (ordy) gone = 1'b1;
                else      blk  = w[i].pos;
            end else begin
                if (blk != w[i].pos + 1) begin
                    w[i].pos++;
                    if (w[i].pos == dep[m] - 1) nl = w[i].d;
                end
                blk = w[i].pos;
            end
        end
        if (gone) void'(w.pop_front());
        free0 = (w.size() == 0) || (w[$].pos != 0);
        if (push) begin
            e.d   = din;
            e.pos = 0;
            w.push_back(e);
            if (dep[m] == 1) nl = din;
        end
        if (commit) begin
            if (m == 0) q0 = w; else q1 = w;
            last_d[m] = nl;
        end
    endtask

    task automatic tick(input bit a_iv, input logic [63:0] a_d, input bit a_or,
                        input bit b_iv, input logic [63:0] b_d, input bit b_or,
                        input bit fl, input bit rs);
        bit f0, f1, r0, r1;
        @(negedge clk);
        iv0 = a_iv; id0 = a_d[W0-1:0]; or0 = a_or;
        iv1 = b_iv; id1 = b_d[W1-1:0]; or1 = b_or;
        flush = fl; rst = rs;
        #1;
        model_step(0, a_or, 1'b0, 64'd0, 1'b0, f0);
        model_step(1, b_or, 1'b0, 64'd0, 1'b0, f1);
        r0 = f0 && !fl && !rs;
        r1 = f1 && !fl && !rs;
        check_eq("in_ready0",  64'(ir0),  64'(r0));
        check_eq("out_valid0", 64'(ov0),  64'(q0.size() > 0 && q0[0].pos == D0 - 1));
        check_eq("out_data0",  64'(od0),  last_d[0]);
        check_eq("count0",     64'(cnt0), 64'(q0.size()));
        check_eq("in_ready1",  64'(ir1),  64'(r1));
        check_eq("out_valid1", 64'(ov1),  64'(q1.size() > 0 && q1[0].pos == D1 - 1));
        check_eq("out_data1",  64'(od1),  last_d[1]);
        check_eq("count1",     64'(cnt1), 64'(q1.size()));
        @(posedge clk);
        if (rs) begin
            q0.delete(); q1.delete();
            last_d[0] = '0; last_d[1] = '0;
        end else if (fl) begin
            q0.delete(); q1.delete();
        end else begin
            model_step(0, a_or, a_iv && r0, 64'(id0), 1'b1, f0);
            model_step(1, b_or, b_iv && r1, 64'(id1), 1'b1, f1);
        end
    endtask

    task automatic t0(input bit iv, input logic [63:0] d, input bit ordy);
        tick(iv, d, ordy, 1'($urandom), 64'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        dep[0] = D0; dep[1] = D1;
        rst = 1'b1; flush = 1'b0;
        iv0 = 1'b0; id0 = '0; or0 = 1'b0;
        iv1 = 1'b0; id1 = '0; or1 = 1'b0;
        repeat (2) @(posedge clk);
        last_d[0] = '0; last_d[1] = '0;

        tick(1'b1, 64'h155, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 1'b1);
        #1;
        check_eq("rst_count",    64'(cnt0), 64'd0);
        check_eq("rst_out_data", 64'(od0),  64'd0);
        check_eq("rst_in_ready", 64'(ir0),  64'd0);

        // Streaming: first word visible after DEPTH-1 further edges
        for (int i = 1; i <= 8; i++) begin
            t0(1'b1, 64'(i), 1'b1);
            #1;
            if (i == 3) check_eq("lat_not_yet", 64'(ov0), 64'd0);
            if (i == 4) check_eq("lat_first",   64'(od0), 64'h001);
        end
        repeat (5) t0(1'b0, 64'd0, 1'b1);

        // Back-pressure until full, then release
        t0(1'b1, 64'h3FF, 1'b0);
        t0(1'b1, 64'h155, 1'b0);
        t0(1'b1, 64'h2AA, 1'b0);
        t0(1'b1, 64'h0F0, 1'b0);
        t0(1'b1, 64'h00F, 1'b0);
        t0(1'b1, 64'h00F, 1'b0);
        #1;
        check_eq("full_count",    64'(cnt0), 64'd4);
        check_eq("full_in_ready", 64'(ir0),  64'd0);
        check_eq("full_hold",     64'(od0),  64'h3FF);
        t0(1'b1, 64'h00F, 1'b1);
        repeat (6) t0(1'b0, 64'd0, 1'b1);

        // Full pipe flowing at rate
        for (int i = 0; i < 4; i++) t0(1'b1, 64'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) t0(1'b1, 64'($urandom), 1'b1);
        #1;
        check_eq("flow_count", 64'(cnt0), 64'd4);
        repeat (5) t0(1'b0, 64'd0, 1'b1);

        // Flush with three words held and a word offered
        for (int i = 0; i < 3; i++) t0(1'b1, 64'(8'h11 * (i + 1)), 1'b0);
        tick(1'b1, 64'h2A5, 1'b0, 1'b1, 64'd1, 1'b0, 1'b1, 1'b0);
        #1;
        check_eq("flush_count", 64'(cnt0), 64'd0);
        check_eq("flush_valid", 64'(ov0),  64'd0);
        repeat (6) t0(1'b0, 64'd0, 1'b1);

        // Reset mid-stream with a full pipe
        for (int i = 0; i < 4; i++) t0(1'b1, 64'($urandom), 1'b0);
        tick(1'b1, 64'h1AB, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 1'b1);
        #1;
        check_eq("midrst_out_data", 64'(od0), 64'd0);
        check_eq("midrst_count",    64'(cnt0), 64'd0);
        check_eq("midrst_in_ready", 64'(ir0), 64'd0);
        t0(1'b1, 64'h123, 1'b1);
        t0(1'b0, 64'd0, 1'b1);
        t0(1'b0, 64'd0, 1'b1);
        #1;
        check_eq("post_rst_early", 64'(ov0), 64'd0);
        t0(1'b0, 64'd0, 1'b1);
        #1;
        check_eq("post_rst_valid", 64'(ov0), 64'd1);
        check_eq("post_rst_data",  64'(od0), 64'h123);

        // Single-stage build: alternating out_ready with continuous offers
        for (int i = 0; i < 12; i++) begin
            tick(1'($urandom), 64'($urandom), 1'($urandom),
                 1'b1, 64'(i), 1'(i % 2 == 0), 1'b0, 1'b0);
        end

        for (int i = 0; i < 1500; i++) begin
            tick(1'($urandom_range(3) != 0), 64'($urandom), 1'($urandom_range(1)),
                 1'($urandom_range(3) != 0), 64'($urandom), 1'($urandom_range(1)),
                 1'($urandom_range(39) == 0), 1'($urandom_range(149) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_pipe_bdeduffy.md
REGISTER_PIPE_BDEDUFFY -- requirements
Module: register_pipe_bdeduffy

Interface
REQ-001 Parameter WIDTH, default 10, data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of pipeline stages; legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all held data.
REQ-006 in_valid  input  1  upstream word present on in_data.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  stage DEPTH-1 holds a word.
REQ-010 out_data  output  WIDTH  word in stage DEPTH-1.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-013 The block SHALL be an elastic chain of DEPTH stages; each stage holds a valid bit and a WIDTH-bit data register.
REQ-014 Transfer in: in_valid && in_ready at a posedge SHALL load in_data into stage 0 and set its valid bit.
REQ-015 Transfer out: out_valid && out_ready at a posedge SHALL clear the last stage's valid bit unless the previous stage moves into it in the same cycle.
REQ-016 Stage k SHALL advance into stage k+1 when stage k is valid and stage k+1 is empty or moving out in the same cycle (bubble collapsing).
REQ-017 in_ready SHALL be combinational: high when stage 0 is empty or stage 0 moves this cycle, and low whenever flush or rst is high.
REQ-018 Latency: with out_ready held high, a word accepted at edge N SHALL appear with out_valid high after edge N+DEPTH-1. For DEPTH=1 it appears immediately after the accepting edge.
REQ-019 Throughput: with out_ready held high and in_valid held high, the block SHALL accept and deliver one word per cycle with no bubbles.
REQ-020 Order: words SHALL exit in acceptance order; none SHALL be duplicated or dropped except by flush or rst.
REQ-021 Full: when all DEPTH stages are valid and out_ready is low, in_ready SHALL be 0 and all data SHALL hold.
REQ-022 Full with out_ready high: simultaneous accept and drain SHALL be allowed, and count SHALL remain DEPTH.
REQ-023 Empty: out_valid SHALL be 0, and out_ready SHALL be ignored.
REQ-024 out_data SHALL be stable while out_valid is high and out_ready is low.
REQ-025 count SHALL be registered and equal to the popcount of stage valid bits after each edge; it SHALL increment on accept-only, decrement on drain-only, and hold otherwise.
REQ-026 flush SHALL clear all valid bits and set count to 0 at the edge. Simultaneous in_valid SHALL be ignored, and the word presented at out_data that cycle SHALL be discarded regardless of out_ready.
REQ-027 Data registers of empty stages SHALL hold their last value; only out_data of stage DEPTH-1 is observable.

Reset
REQ-028 rst high at a posedge SHALL clear all valid bits and data registers to 0, so out_valid=0, out_data=0, count=0.
REQ-029 rst SHALL take priority over flush and all transfers, including when asserted mid-stream with a full pipe.
REQ-030 in_ready SHALL be 0 during rst and SHALL go to 1 in the first cycle after rst deasserts.

Structure
REQ-031 Default WIDTH and DEPTH values and the count-width function SHALL live in the shared header register_pipe_defs_bdeduffy, included by RTL and bench.
REQ-032 One sub-module, register_pipe_stage_bdeduffy, SHALL implement a single stage. It SHALL hold a WIDTH-bit data register with load enable plus a valid flop with set, clear and synchronous reset, and be instantiated DEPTH times in a generate loop.
REQ-033 The ready/advance chain SHALL be pure combinational logic in the top module, with no registered ready.

Verification
REQ-034 WIDTH=10, DEPTH=4, out_ready=1: push 0x001..0x008 on consecutive cycles -> 0x001 appears after 3 edges, then one word per cycle in order; count peaks at 4.
REQ-035 out_ready=0: push 0x3FF, 0x155, 0x2AA, 0x0F0, 0x00F -> count=4 and in_ready=0 after the fourth accept; 0x00F is not taken; out_data=0x3FF is stable. Raising out_ready drains 0x3FF..0x0F0, then 0x00F is accepted.
REQ-036 Full pipe with in_valid=1 and out_ready=1 for 10 cycles -> count stays 4 and 10 words pass with no gap.
REQ-037 Three words held, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, and the flushed-cycle input is absent from later output.
REQ-038 Full pipe, assert rst for 1 cycle -> out_data=0x000, count=0, in_ready=0 during rst and 1 on the next cycle; a fresh push of 0x123 exits after 3 edges.
REQ-039 DEPTH=1 and WIDTH=1 builds: alternate out_ready 1/0 with continuous in_valid -> one word per two cycles, order preserved.
